// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - shared states, ASCII constants and helpers for the boot loader
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WRITE = 3'd2,
    ST_SKIP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_EOT   = 8'h04;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_AT    = 8'h40;

  // Whitespace that terminates a hex token.
  function automatic logic is_separator(input logic [7:0] b);
    return (b == ASCII_SPACE) || (b == ASCII_TAB) || (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/hex_nibble_decode.sv
// rtl/hex_nibble_decode.sv - combinational ASCII hex digit to nibble decoder
module hex_nibble_decode (
  input  logic [7:0] ascii,
  output logic       is_hex,
  output logic [3:0] nibble
);

  // Letters share a low nibble of 1..6 for both cases, so adding 9 yields 10..15.
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      is_hex = 1'b1;
      nibble = ascii[3:0];
    end else if ((ascii >= 8'h41 && ascii <= 8'h46) || (ascii >= 8'h61 && ascii <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = ascii[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/boot_loader_ctrl.sv
// rtl/boot_loader_ctrl.sv - ASCII hex stream loader that fills program memory then releases the CPU
module boot_loader_ctrl
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int MAX_DIGITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  input  logic              mem_wr_ready,
  output logic              cpu_reset,
  output logic              boot_done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0]  DIGITS_MAX = CNT_W'(MAX_DIGITS);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
  localparam logic [ADDR_W:0]   CNT_SAT    = {1'b1, {ADDR_W{1'b0}}};

  state_t           state;
  logic [31:0]      acc;
  logic [CNT_W-1:0] digit_cnt;
  logic             eot_pending;
  logic             is_hex;
  logic [3:0]       nibble;
  logic             rx_fire;

  hex_nibble_decode u_hex_nibble_decode (
    .ascii  (rx_data),
    .is_hex (is_hex),
    .nibble (nibble)
  );

  assign rx_fire = rx_valid & rx_ready;

  // Parser FSM; mem_wr_addr doubles as the running load address and every output is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_LOAD;
      acc         <= '0;
      digit_cnt   <= '0;
      eot_pending <= 1'b0;
      rx_ready    <= 1'b1;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      cpu_reset   <= 1'b1;
      boot_done   <= 1'b0;
      err         <= 1'b0;
      word_cnt    <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (rx_fire) begin
            if (is_hex) begin
              if (digit_cnt == DIGITS_MAX) begin
                err   <= 1'b1;
                state <= ST_SKIP;
              end else begin
                acc       <= {acc[27:0], nibble};
                digit_cnt <= digit_cnt + 1'b1;
              end
            end else if (is_separator(rx_data)) begin
              if (digit_cnt != '0) begin
                state       <= ST_WRITE;
                mem_wr_en   <= 1'b1;
                mem_wr_data <= acc;
                rx_ready    <= 1'b0;
              end
            end else if (rx_data == ASCII_AT) begin
              state     <= ST_ADDR;
              acc       <= '0;
              digit_cnt <= '0;
            end else if (rx_data == ASCII_EOT) begin
              rx_ready <= 1'b0;
              if (digit_cnt != '0) begin
                state       <= ST_WRITE;
                mem_wr_en   <= 1'b1;
                mem_wr_data <= acc;
                eot_pending <= 1'b1;
              end else begin
                state     <= ST_DONE;
                cpu_reset <= 1'b0;
                boot_done <= 1'b1;
              end
            end else begin
              err   <= 1'b1;
              state <= ST_SKIP;
            end
          end
        end

        ST_ADDR: begin
          if (rx_fire) begin
            if (is_hex) begin
              if (digit_cnt == DIGITS_MAX) begin
                err   <= 1'b1;
                state <= ST_SKIP;
              end else begin
                acc       <= {acc[27:0], nibble};
                digit_cnt <= digit_cnt + 1'b1;
              end
            end else if (is_separator(rx_data)) begin
              mem_wr_addr <= acc[ADDR_W-1:0];
              acc         <= '0;
              digit_cnt   <= '0;
              state       <= ST_LOAD;
            end else begin
              err   <= 1'b1;
              state <= ST_SKIP;
            end
          end
        end

        ST_WRITE: begin
          if (mem_wr_ready) begin
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= mem_wr_addr + 1'b1;
            acc         <= '0;
            digit_cnt   <= '0;
            if (mem_wr_addr == ADDR_LAST) err <= 1'b1;
            if (word_cnt != CNT_SAT) word_cnt <= word_cnt + 1'b1;
            if (eot_pending) begin
              eot_pending <= 1'b0;
              state       <= ST_DONE;
              cpu_reset   <= 1'b0;
              boot_done   <= 1'b1;
            end else begin
              state    <= ST_LOAD;
              rx_ready <= 1'b1;
            end
          end
        end

        ST_SKIP: begin
          if (rx_fire && rx_data == ASCII_LF) begin
            acc       <= '0;
            digit_cnt <= '0;
            state     <= ST_LOAD;
          end
        end

        ST_DONE: begin
          if (load_req) begin
            state       <= ST_LOAD;
            rx_ready    <= 1'b1;
            cpu_reset   <= 1'b1;
            boot_done   <= 1'b0;
            word_cnt    <= '0;
            mem_wr_addr <= '0;
            acc         <= '0;
            digit_cnt   <= '0;
          end
        end

        default: begin
          state    <= ST_LOAD;
          rx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
